// File: rtl/program_sequencer.sv
// program_sequencer: instruction-fetch stage in front of the instruction ROM.
// Owns the PC, registers the returned word for the decoder and redirects
// fetch on jump/call/return through a hardware return-address stack.
// Optional timed-NOP delay: define PROGRAM_SEQUENCER_NOP_DELAY_EN.
module program_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 28,
  parameter int unsigned STACK_DEPTH = 8
`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
  ,
  parameter logic [3:0]  NOP_OPCODE  = 4'h0
`endif
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0]  oInstrAddr,
  output logic                   oValid,
  input  logic                   iStall,
  input  logic                   iJump,
  input  logic                   iCall,
  input  logic                   iRet,
  input  logic [ADDR_WIDTH-1:0]  iTarget,
  output logic                   oStackOverflow,
  output logic                   oStackUnderflow
);

  // Pointer counts 0..STACK_DEPTH, so it needs one more state than the index.
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0]  r_pc, w_pc_n;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_n;
  logic [ADDR_WIDTH-1:0]  r_instr_addr, w_instr_addr_n;
  logic                   r_valid, w_valid_n;
  logic [SP_W-1:0]        r_sp, w_sp_n;
  logic                   r_ovf, w_ovf_n;
  logic                   r_unf, w_unf_n;
  logic [ADDR_WIDTH-1:0]  r_stack [STACK_DEPTH];

  logic                   w_push;
  logic [IDX_W-1:0]       w_push_idx;
  logic [IDX_W-1:0]       w_top_idx;
  logic [ADDR_WIDTH-1:0]  w_push_data;
  logic                   w_full;
  logic                   w_fetch_ok;

`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
  localparam int unsigned IMM_W = INSTR_WIDTH - 4;
  logic [IMM_W-1:0]       r_dly, w_dly_n;
  logic                   w_nop_load;
`endif

  assign oAddress        = r_pc;
  assign oInstruction    = r_instr;
  assign oInstrAddr      = r_instr_addr;
  assign oValid          = r_valid;
  assign oStackOverflow  = r_ovf;
  assign oStackUnderflow = r_unf;

  assign w_full      = (r_sp == SP_W'(STACK_DEPTH));
  assign w_push_idx  = IDX_W'(r_sp);
  assign w_top_idx   = IDX_W'(r_sp - SP_W'(1));
  assign w_push_data = r_instr_addr + ADDR_WIDTH'(1);

  // Next-state: redirect (ret > call > jump) beats stall beats sequential fetch.
  always_comb begin
    w_pc_n         = r_pc;
    w_instr_n      = r_instr;
    w_instr_addr_n = r_instr_addr;
    w_valid_n      = r_valid;
    w_sp_n         = r_sp;
    w_ovf_n        = r_ovf;
    w_unf_n        = r_unf;
    w_push         = 1'b0;
    w_fetch_ok     = 1'b1;
`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
    w_dly_n    = r_dly;
    w_nop_load = r_valid
               && (r_instr[INSTR_WIDTH-1 -: 4] == NOP_OPCODE)
               && (r_instr[IMM_W-1:0] != '0);
    // The last delay cycle already fetches so exactly imm bubbles appear.
    if (r_dly != '0) begin
      w_dly_n    = r_dly - IMM_W'(1);
      w_fetch_ok = (r_dly == IMM_W'(1));
    end
`endif
    if (r_valid && iRet) begin
      w_valid_n = 1'b0;
      if (r_sp == '0) begin
        w_pc_n  = '0;
        w_unf_n = 1'b1;
      end else begin
        w_pc_n = r_stack[w_top_idx];
        w_sp_n = r_sp - SP_W'(1);
      end
    end else if (r_valid && iCall) begin
      w_valid_n = 1'b0;
      w_pc_n    = iTarget;
      if (w_full) begin
        w_ovf_n = 1'b1;
      end else begin
        w_push = 1'b1;
        w_sp_n = r_sp + SP_W'(1);
      end
    end else if (r_valid && iJump) begin
      w_valid_n = 1'b0;
      w_pc_n    = iTarget;
    end else if (iStall) begin
      w_valid_n = r_valid;
`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
    end else if (w_nop_load) begin
      w_valid_n = 1'b0;
      w_dly_n   = r_instr[IMM_W-1:0];
`endif
    end else if (w_fetch_ok) begin
      w_instr_n      = iInstruction;
      w_instr_addr_n = r_pc;
      w_valid_n      = 1'b1;
      w_pc_n         = r_pc + ADDR_WIDTH'(1);
    end else begin
      w_valid_n = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc         <= '0;
      r_instr      <= '0;
      r_instr_addr <= '0;
      r_valid      <= 1'b0;
      r_sp         <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
      r_dly        <= '0;
`endif
    end else begin
      r_pc         <= w_pc_n;
      r_instr      <= w_instr_n;
      r_instr_addr <= w_instr_addr_n;
      r_valid      <= w_valid_n;
      r_sp         <= w_sp_n;
      r_ovf        <= w_ovf_n;
      r_unf        <= w_unf_n;
`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
      r_dly        <= w_dly_n;
`endif
    end
  end

  // Return-address storage; contents are don't-care while the pointer is 0.
  always_ff @(posedge Clock) begin
    if (!Reset && w_push) begin
      r_stack[w_push_idx] <= w_push_data;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: fetch, call/return, nested stack
// overflow/underflow, stall vs redirect, PC wrap and optional NOP delay.
module tb_program_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oInstrAddr;
  logic        oValid;
  logic        iStall;
  logic        iJump;
  logic        iCall;
  logic        iRet;
  logic [15:0] iTarget;
  logic        oStackOverflow;
  logic        oStackUnderflow;

  logic        rom_nop = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 Clock = ~Clock;

  // ROM: opcode 1 with the address in the low bits; optional NOP imm=3 at 0.
  assign iInstruction = (rom_nop && (oAddress == 16'h0000)) ? 28'h0000003
                                                            : {4'h1, 8'h00, oAddress};

  program_sequencer dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress),
    .iInstruction(iInstruction), .oInstruction(oInstruction),
    .oInstrAddr(oInstrAddr), .oValid(oValid), .iStall(iStall),
    .iJump(iJump), .iCall(iCall), .iRet(iRet), .iTarget(iTarget),
    .oStackOverflow(oStackOverflow), .oStackUnderflow(oStackUnderflow)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] word_at(input logic [15:0] a);
    return (rom_nop && a == 16'h0000) ? 28'h0000003 : {4'h1, 8'h00, a};
  endfunction

  // Expected fetch-stage state: valid, fetched address (if valid), PC.
  task automatic exp_fetch(input string tag, input logic v, input logic [15:0] ia,
                           input logic [15:0] pc);
    chk({tag, ".valid"}, 32'(oValid), 32'(v));
    chk({tag, ".pc"}, 32'(oAddress), 32'(pc));
    if (v) begin
      chk({tag, ".iaddr"}, 32'(oInstrAddr), 32'(ia));
      chk({tag, ".instr"}, 32'(oInstruction), 32'(word_at(ia)));
    end
  endtask

  task automatic exp_flags(input string tag, input logic ov, input logic un);
    chk({tag, ".ovf"}, 32'(oStackOverflow), 32'(ov));
    chk({tag, ".unf"}, 32'(oStackUnderflow), 32'(un));
  endtask

  logic [15:0] tgt;
  logic [15:0] ret_addr;

  initial begin
    Reset = 1'b1; iStall = 1'b0; iJump = 1'b0; iCall = 1'b0; iRet = 1'b0;
    iTarget = 16'h0000;
    step(); step();
    exp_fetch("rst", 1'b0, 16'h0, 16'h0);
    chk("rst.iaddr", 32'(oInstrAddr), 32'h0);
    chk("rst.instr", 32'(oInstruction), 32'h0);
    exp_flags("rst", 1'b0, 1'b0);

    // Sequential fetch after reset release.
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_fetch("seq", 1'b1, 16'(i), 16'(i + 1));
    end

    // Call at address 5 to 0x20, return at 0x23 back to 6.
    iCall = 1'b1; iTarget = 16'h0020;
    step(); exp_fetch("call.bubble", 1'b0, 16'h0, 16'h0020);
    iCall = 1'b0;
    step(); exp_fetch("call.tgt", 1'b1, 16'h0020, 16'h0021);
    step(); step(); step();
    exp_fetch("call.body", 1'b1, 16'h0023, 16'h0024);
    iRet = 1'b1;
    step(); exp_fetch("ret.bubble", 1'b0, 16'h0, 16'h0006);
    iRet = 1'b0;
    step(); exp_fetch("ret.tgt", 1'b1, 16'h0006, 16'h0007);
    step(); exp_fetch("pre.stall", 1'b1, 16'h0007, 16'h0008);

    // Stall three cycles at 7, then jump to 0x40 while still stalled.
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); exp_fetch("stall", 1'b1, 16'h0007, 16'h0008);
    end
    iJump = 1'b1; iTarget = 16'h0040;
    step(); exp_fetch("stalljmp.bubble", 1'b0, 16'h0, 16'h0040);
    iJump = 1'b0; iStall = 1'b0;
    step(); exp_fetch("stalljmp.tgt", 1'b1, 16'h0040, 16'h0041);
    exp_flags("after.ret", 1'b0, 1'b0);

    // Nine nested calls; the ninth overflows but still jumps.
    for (int k = 0; k < 9; k++) begin
      tgt = 16'h0100 + 16'(k * 16);
      iCall = 1'b1; iTarget = tgt;
      step(); exp_fetch("ncall.bubble", 1'b0, 16'h0, tgt);
      iCall = 1'b0;
      step(); exp_fetch("ncall.tgt", 1'b1, tgt, tgt + 16'h1);
      exp_flags("ncall", (k == 8), 1'b0);
    end

    // Eight returns unwind in LIFO order.
    for (int j = 1; j <= 8; j++) begin
      ret_addr = (j == 8) ? 16'h0041 : 16'h0100 + 16'((7 - j) * 16) + 16'h1;
      iRet = 1'b1;
      step(); exp_fetch("nret.bubble", 1'b0, 16'h0, ret_addr);
      iRet = 1'b0;
      step(); exp_fetch("nret.tgt", 1'b1, ret_addr, ret_addr + 16'h1);
      exp_flags("nret", 1'b1, 1'b0);
    end

    // Ninth return underflows to PC 0.
    iRet = 1'b1;
    step(); exp_fetch("uret.bubble", 1'b0, 16'h0, 16'h0000);
    iRet = 1'b0;
    exp_flags("uret", 1'b1, 1'b1);
    step(); exp_fetch("uret.tgt", 1'b1, 16'h0000, 16'h0001);

    // PC wrap at 0xFFFF.
    iJump = 1'b1; iTarget = 16'hFFFE;
    step(); exp_fetch("wrap.bubble", 1'b0, 16'h0, 16'hFFFE);
    iJump = 1'b0;
    step(); exp_fetch("wrap.fffe", 1'b1, 16'hFFFE, 16'hFFFF);
    step(); exp_fetch("wrap.ffff", 1'b1, 16'hFFFF, 16'h0000);
    step(); exp_fetch("wrap.0000", 1'b1, 16'h0000, 16'h0001);
    exp_flags("sticky", 1'b1, 1'b1);

    // Reset while stalled clears everything, including sticky flags.
    iStall = 1'b1; Reset = 1'b1;
    step();
    exp_fetch("rst2", 1'b0, 16'h0, 16'h0);
    exp_flags("rst2", 1'b0, 1'b0);
    iStall = 1'b0;

`ifdef PROGRAM_SEQUENCER_NOP_DELAY_EN
    // NOP imm=3 at address 0: three bubbles, jump during delay ignored.
    rom_nop = 1'b1;
    step();
    Reset = 1'b0;
    step(); exp_fetch("nop.word", 1'b1, 16'h0000, 16'h0001);
    step(); exp_fetch("nop.d1", 1'b0, 16'h0, 16'h0001);
    iJump = 1'b1; iTarget = 16'h0050;
    step(); exp_fetch("nop.d2", 1'b0, 16'h0, 16'h0001);
    iJump = 1'b0;
    step(); exp_fetch("nop.d3", 1'b0, 16'h0, 16'h0001);
    step(); exp_fetch("nop.resume", 1'b1, 16'h0001, 16'h0002);
    step(); exp_fetch("nop.next", 1'b1, 16'h0002, 16'h0003);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Instruction-fetch stage sitting directly upstream of the 28-bit instruction ROM.
- Owns the program counter and drives the ROM address.
- Registers the returned instruction for the decoder.
- Redirects fetch on jump, call and return, using a hardware return-address stack.

Parameters:
ADDR_WIDTH, 16, width of program counter and ROM address
INSTR_WIDTH, 28, instruction word width
STACK_DEPTH, 8, return-address stack entries (≥1)
NOP_OPCODE, 4'h0, opcode in bits [27:24] treated as timed NOP (optional feature only)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high
oAddress  output  ADDR_WIDTH  ROM address; equals PC, combinational from PC register
iInstruction  input  INSTR_WIDTH  ROM data for oAddress, same cycle
oInstruction  output  INSTR_WIDTH  registered instruction to decoder
oInstrAddr  output  ADDR_WIDTH  address that oInstruction was fetched from
oValid  output  1  oInstruction is live this cycle
iStall  input  1  decoder cannot accept; hold everything
iJump  input  1  redirect PC to iTarget
iCall  input  1  push return address, redirect PC to iTarget
iRet  input  1  pop return address into PC
iTarget  input  ADDR_WIDTH  jump/call destination
oStackOverflow  output  1  sticky: call while stack full
oStackUnderflow  output  1  sticky: return while stack empty

Behaviour:
- Reset (any cycle, including mid-stall or mid-delay) clears state to:
  - PC=0, oInstruction=0, oInstrAddr=0, oValid=0
  - stack pointer=0, both error flags=0, delay counter=0
- Redirect inputs are sampled only when oValid=1. They are ignored when oValid=0.
- Priority, highest first: Reset > iRet > iCall > iJump > iStall > sequential fetch.
- Sequential fetch (no stall, no redirect):
  - oInstruction<=iInstruction, oInstrAddr<=PC, oValid<=1.
  - PC<=PC+1, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0).
- Stall: PC, oInstruction, oInstrAddr and oValid hold. A redirect in the same cycle overrides the stall.
- Any redirect:
  - The word fetched this cycle is discarded and oValid<=0 next cycle (one bubble).
  - The target's instruction appears with oValid=1 two cycles after the redirect edge.
- iJump: PC<=iTarget.
- iCall:
  - Pushes oInstrAddr+1 (modulo wrap) and sets PC<=iTarget.
  - If the stack is full: no push, oStackOverflow<=1, jump still taken.
- iRet:
  - Pops the top entry and sets PC to it.
  - If the stack is empty: PC<=0, oStackUnderflow<=1, pointer stays 0.
- Stack is LIFO with a pointer of 0..STACK_DEPTH. Nested calls to full depth are legal.
- Error flags clear only on Reset.

Optional Feature:
PROGRAM_SEQUENCER_NOP_DELAY_EN
- Defined:
  - When oValid=1, iStall=0, oInstruction[27:24]==NOP_OPCODE and imm=oInstruction[23:0]≠0, load a 24-bit delay counter with imm.
  - While the counter is nonzero: PC holds, oValid=0, redirects are ignored, and the counter decrements by 1 per cycle.
  - Fetch resumes when the counter reaches 0. This inserts exactly imm bubble cycles.
  - imm=0 inserts no delay.
- Undefined: NOP_OPCODE words pass through like any other instruction. Counter logic is absent.

Test Plan:
1. Reset, then run 4 cycles, ROM returns word=address → oValid rises one cycle after reset deasserts; oInstrAddr sequence 0,1,2,3; oAddress 1,2,3,4.
2. At oInstrAddr=5 pulse iCall with iTarget=0x20; at oInstrAddr=0x23 pulse iRet → one bubble after each; next valid addresses are 0x20 and then 6; stack empty afterwards.
3. STACK_DEPTH=8: issue 9 nested calls → oStackOverflow=1 after the 9th while its jump is still taken; then 8 returns reach the correct addresses in LIFO order; a 9th return sets oStackUnderflow=1 and PC=0.
4. Hold iStall=1 for 3 cycles at oInstrAddr=7 → oInstruction and oAddress are frozen; assert iJump to 0x40 with iStall=1 → redirect wins, next valid address 0x40.
5. PC=0xFFFF sequential → next oAddress=0x0000, oInstrAddr=0xFFFF then 0x0000.
6. With PROGRAM_SEQUENCER_NOP_DELAY_EN, NOP imm=3 at address 0 → exactly 3 cycles oValid=0 after it, then address 1 is valid; a pulse of iJump during the delay is ignored.
